// File: rtl/gba_sio_normal_ctrl_if.sv
// Core-side word interface of the GBA link-port Normal-mode controller,
// plus the pin direction type shared with the link-port wrapper.
typedef enum logic {DIR_IN = 1'b0, DIR_OUT = 1'b1} dir_e;

// Handshake: a word moves on any rising clk edge where tx_valid && tx_ready.
// tx_valid may rise at any time; tx_data and cfg_* are only sampled on that edge.
// rx_valid and err_timeout are single-cycle pulses with no back-pressure.
interface gba_sio_normal_ctrl_if;
  logic        cfg_master;
  logic        cfg_fast;
  logic        cfg_wide;
  logic        tx_valid;
  logic        tx_ready;
  logic [31:0] tx_data;
  logic        rx_valid;
  logic [31:0] rx_data;
  logic        err_timeout;
  logic        busy;

  modport master (
    output cfg_master, cfg_fast, cfg_wide, tx_valid, tx_data,
    input  tx_ready, rx_valid, rx_data, err_timeout, busy
  );

  modport slave (
    input  cfg_master, cfg_fast, cfg_wide, tx_valid, tx_data,
    output tx_ready, rx_valid, rx_data, err_timeout, busy
  );
endinterface

// File: rtl/gba_sio_normal_ctrl.sv
// GBA link-port Normal-mode sequencer: shifts 8/32-bit words MSB-first,
// generating sck as master or following a synchronised external sck as slave.
module gba_sio_normal_ctrl #(
  parameter int HALF_SLOW   = 146,
  parameter int HALF_FAST   = 18,
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT     = 65535
) (
  input  logic                  clk,
  input  logic                  reset_n,
  gba_sio_normal_ctrl_if.slave  bus,
  input  logic                  i_sck_in,
  output logic                  o_sck_out,
  output dir_e                  o_sck_dir,
  output logic                  o_so_out,
  output dir_e                  o_so_dir,
  input  logic                  i_si_in,
  output dir_e                  o_si_dir,
  output dir_e                  o_sd_dir,
  output logic [2:0]            o_dbg_state
);
  localparam int HMAX = (HALF_SLOW > HALF_FAST) ? HALF_SLOW : HALF_FAST;
  localparam int HW   = (HMAX > 1) ? $clog2(HMAX) : 1;
  localparam int TW   = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {IDLE, M_LO, M_HI, S_RUN, DONE, ABORT} state_e;

  state_e                 r_state;
  logic [31:0]            r_shift;
  logic [5:0]             r_bitcnt;
  logic [HW-1:0]          r_half;
  logic [TW-1:0]          r_idle;
  logic                   r_master, r_fast, r_wide, r_first, r_started, r_dir_en;
  logic                   r_tx_ready, r_busy, r_rx_valid, r_err, r_sck_out, r_so_out;
  logic [31:0]            r_rx_data;
  logic [SYNC_STAGES-1:0] r_sck_sync, r_si_sync;
  logic                   r_sck_prev;

  logic        w_sck_s, w_si_s, w_rise, w_fall, w_accept;
  logic [5:0]  w_nbits, w_m_cnt, w_s_cnt;
  logic [31:0] w_m_shift, w_s_shift;
  logic [HW-1:0] w_half_ld;

  assign w_sck_s   = r_sck_sync[SYNC_STAGES-1];
  assign w_si_s    = r_si_sync[SYNC_STAGES-1];
  assign w_rise    = w_sck_s & ~r_sck_prev;
  assign w_fall    = ~w_sck_s & r_sck_prev;
  assign w_nbits   = r_wide ? 6'd32 : 6'd8;
  assign w_half_ld = r_fast ? HW'(HALF_FAST - 1) : HW'(HALF_SLOW - 1);
  // Master samples si only on the first cycle of the high phase.
  assign w_m_shift = r_first ? {r_shift[30:0], i_si_in} : r_shift;
  assign w_m_cnt   = r_first ? r_bitcnt + 6'd1 : r_bitcnt;
  assign w_s_shift = {r_shift[30:0], w_si_s};
  assign w_s_cnt   = r_bitcnt + 6'd1;
  assign w_accept  = (r_state == IDLE) && r_tx_ready && bus.tx_valid;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_sck_sync <= '1;
      r_si_sync  <= '1;
      r_sck_prev <= 1'b1;
    end else begin
      r_sck_sync <= {r_sck_sync[SYNC_STAGES-2:0], i_sck_in};
      r_si_sync  <= {r_si_sync[SYNC_STAGES-2:0], i_si_in};
      r_sck_prev <= w_sck_s;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state    <= IDLE;
      r_shift    <= '0;
      r_bitcnt   <= '0;
      r_half     <= '0;
      r_idle     <= '0;
      r_master   <= 1'b0;
      r_fast     <= 1'b0;
      r_wide     <= 1'b0;
      r_first    <= 1'b0;
      r_started  <= 1'b0;
      r_dir_en   <= 1'b0;
      r_tx_ready <= 1'b0;
      r_busy     <= 1'b0;
      r_rx_valid <= 1'b0;
      r_err      <= 1'b0;
      r_rx_data  <= '0;
      r_sck_out  <= 1'b1;
      r_so_out   <= 1'b1;
    end else begin
      r_rx_valid <= 1'b0;
      r_err      <= 1'b0;
      r_dir_en   <= 1'b1;
      case (r_state)
        IDLE: begin
          r_tx_ready <= 1'b1;
          r_busy     <= 1'b0;
          r_sck_out  <= 1'b1;
          r_so_out   <= 1'b1;
          if (w_accept) begin
            r_tx_ready <= 1'b0;
            r_busy     <= 1'b1;
            r_master   <= bus.cfg_master;
            r_fast     <= bus.cfg_fast;
            r_wide     <= bus.cfg_wide;
            r_shift    <= bus.cfg_wide ? bus.tx_data : {bus.tx_data[7:0], 24'h0};
            r_so_out   <= bus.cfg_wide ? bus.tx_data[31] : bus.tx_data[7];
            r_bitcnt   <= '0;
            r_first    <= 1'b0;
            r_started  <= 1'b0;
            r_idle     <= '0;
            r_half     <= bus.cfg_fast ? HW'(HALF_FAST - 1) : HW'(HALF_SLOW - 1);
            if (bus.cfg_master) begin
              r_state   <= M_LO;
              r_sck_out <= 1'b0;
            end else begin
              r_state <= S_RUN;
            end
          end
        end
        M_LO: begin
          if (r_half == '0) begin
            r_state   <= M_HI;
            r_sck_out <= 1'b1;
            r_half    <= w_half_ld;
            r_first   <= 1'b1;
          end else begin
            r_half <= r_half - HW'(1);
          end
        end
        M_HI: begin
          r_first  <= 1'b0;
          r_shift  <= w_m_shift;
          r_bitcnt <= w_m_cnt;
          if (r_half == '0) begin
            if (w_m_cnt == w_nbits) begin
              r_state    <= DONE;
              r_rx_valid <= 1'b1;
              r_rx_data  <= r_wide ? w_m_shift : {24'h0, w_m_shift[7:0]};
              r_so_out   <= 1'b1;
            end else begin
              r_state   <= M_LO;
              r_sck_out <= 1'b0;
              r_so_out  <= w_m_shift[31];
              r_half    <= w_half_ld;
            end
          end else begin
            r_half <= r_half - HW'(1);
          end
        end
        S_RUN: begin
          // Idle timer only arms once the remote master has produced an edge.
          if (w_rise) begin
            r_shift   <= w_s_shift;
            r_bitcnt  <= w_s_cnt;
            r_idle    <= '0;
            r_started <= 1'b1;
            if (w_s_cnt == w_nbits) begin
              r_state    <= DONE;
              r_rx_valid <= 1'b1;
              r_rx_data  <= r_wide ? w_s_shift : {24'h0, w_s_shift[7:0]};
              r_so_out   <= 1'b1;
            end
          end else if (w_fall) begin
            r_so_out  <= r_shift[31];
            r_idle    <= '0;
            r_started <= 1'b1;
          end else if (r_started) begin
            if (r_idle == TW'(TIMEOUT - 1)) begin
              r_state  <= ABORT;
              r_err    <= 1'b1;
              r_so_out <= 1'b1;
            end else begin
              r_idle <= r_idle + TW'(1);
            end
          end
        end
        DONE, ABORT: begin
          r_state    <= IDLE;
          r_tx_ready <= 1'b1;
          r_busy     <= 1'b0;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.tx_ready    = r_tx_ready;
  assign bus.busy        = r_busy;
  assign bus.rx_valid    = r_rx_valid;
  assign bus.rx_data     = r_rx_data;
  assign bus.err_timeout = r_err;
  assign o_sck_out       = r_sck_out;
  assign o_so_out        = r_so_out;
  // Direction follows the live cfg while idle so the pin is ready before accept.
  assign o_sck_dir   = (r_dir_en && ((r_state == IDLE) ? bus.cfg_master : r_master)) ? DIR_OUT : DIR_IN;
  assign o_so_dir    = r_dir_en ? DIR_OUT : DIR_IN;
  assign o_si_dir    = DIR_IN;
  assign o_sd_dir    = DIR_IN;
  assign o_dbg_state = r_state;
endmodule

// File: tb/tb_gba_sio_normal_ctrl.sv
// Self-checking bench for gba_sio_normal_ctrl: directed link-port scenarios plus
// randomized master/slave transfers against a word-level reference model.
module tb_gba_sio_normal_ctrl;
  localparam int HF = 2;
  localparam int HS = 3;
  localparam int SS = 2;
  localparam int TO = 100;
  localparam int SH = 20;

  logic clk, reset_n;
  logic sck_drv, si_drv, lb;
  logic sck_out, so_out, si_in;
  dir_e sck_dir, so_dir, si_dir, sd_dir;
  logic [2:0] dbg_state;

  int n_checks, n_fail, cyc, rx_cnt, err_cnt, rx_cyc, err_cyc, acc_cyc;
  logic [31:0] exp_q[$];

  gba_sio_normal_ctrl_if bus ();

  assign si_in = lb ? so_out : si_drv;

  gba_sio_normal_ctrl #(
    .HALF_SLOW(HS), .HALF_FAST(HF), .SYNC_STAGES(SS), .TIMEOUT(TO)
  ) dut (
    .clk(clk), .reset_n(reset_n), .bus(bus),
    .i_sck_in(sck_drv), .o_sck_out(sck_out), .o_sck_dir(sck_dir),
    .o_so_out(so_out), .o_so_dir(so_dir), .i_si_in(si_in),
    .o_si_dir(si_dir), .o_sd_dir(sd_dir), .o_dbg_state(dbg_state)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  // scoreboard: every rx_valid pulse pops one expected word
  always @(negedge clk) begin
    if (bus.rx_valid === 1'b1) begin
      rx_cnt++;
      rx_cyc = cyc;
      check("rx_pending", 32'(exp_q.size() > 0), 1);
      if (exp_q.size() > 0) check("rx_data", bus.rx_data, exp_q.pop_front());
    end
    if (bus.err_timeout === 1'b1) begin
      err_cnt++;
      err_cyc = cyc;
    end
  end

  task automatic check_reset_vals(input string tag);
    check({tag, "_ctl"}, {bus.tx_ready, bus.busy, bus.rx_valid, bus.err_timeout,
                          sck_out, so_out, sck_dir, so_dir}, 8'b0000_1100);
    check({tag, "_rxd"}, bus.rx_data, 0);
  endtask

  // driver: offer a word and return on cycle 1 of the accepted transfer
  task automatic start(input bit m, input bit f, input bit w, input logic [31:0] tx);
    bus.cfg_master = m;
    bus.cfg_fast   = f;
    bus.cfg_wide   = w;
    bus.tx_data    = tx;
    bus.tx_valid   = 1'b1;
    acc_cyc = -1;
    for (int i = 0; i < 50; i++) begin
      if (bus.tx_ready === 1'b1) begin
        acc_cyc = cyc;
        break;
      end
      tick();
    end
    check("accept", 32'(acc_cyc >= 0), 1);
    tick();
    bus.tx_valid   = 1'b0;
    bus.cfg_master = 1'($urandom_range(0, 1));
    bus.cfg_fast   = 1'($urandom_range(0, 1));
    bus.cfg_wide   = 1'($urandom_range(0, 1));
    check("busy_c1", {bus.busy, bus.tx_ready}, 2'b10);
  endtask

  task automatic run_master(input bit f, input bit w, input logic [31:0] tx,
                            input logic [31:0] si_w, input bit loop);
    int h, n, pulses, bad, run, rx0;
    logic prev;
    logic [31:0] so_w, exp_rx, exp_so;
    h = f ? HF : HS;
    n = w ? 32 : 8;
    exp_rx = loop ? tx : si_w;
    if (!w) exp_rx = exp_rx & 32'hFF;
    exp_so = w ? tx : (tx & 32'hFF);
    exp_q.push_back(exp_rx);
    lb = loop; si_drv = 1'b0; rx0 = rx_cnt;
    pulses = 0; bad = 0; run = 0; prev = 1'b1; so_w = '0;
    start(1'b1, f, w, tx);
    for (int k = 0; k < 2 * h * n + 8; k++) begin
      if (rx_cnt != rx0) break;
      if (sck_out !== prev) begin
        if (sck_out === 1'b0) begin
          if (pulses > 0 && run != h) bad++;
          pulses++;
          so_w = {so_w[30:0], so_out};
          if (!loop && pulses <= n) si_drv = si_w[n - pulses];
        end else if (run != h) begin
          bad++;
        end
        run = 1;
        prev = sck_out;
      end else begin
        run++;
      end
      tick();
    end
    check("m_rx_cnt", rx_cnt - rx0, 1);
    check("m_rx_lat", rx_cyc - acc_cyc, 2 * h * n + 1);
    check("m_pulses", pulses, n);
    check("m_phase_len", bad, 0);
    check("m_so_bits", so_w, exp_so);
    check("m_so_done", so_out, 1);
    tick();
    check("m_idle", {bus.tx_ready, bus.busy, bus.rx_valid}, 3'b100);
    lb = 1'b0;
  endtask

  task automatic run_slave(input bit w, input logic [31:0] tx, input logic [31:0] si_w);
    int n, rx0, dir_bad, rise_cyc;
    logic [31:0] so_w, exp_so;
    n = w ? 32 : 8;
    exp_so = w ? tx : (tx & 32'hFF);
    exp_q.push_back(w ? si_w : (si_w & 32'hFF));
    rx0 = rx_cnt; dir_bad = 0; so_w = '0; lb = 1'b0; rise_cyc = 0;
    start(1'b0, 1'($urandom_range(0, 1)), w, tx);
    check("s_so_c1", so_out, exp_so[n - 1]);
    for (int i = 0; i < n; i++) begin
      sck_drv = 1'b0;
      si_drv  = si_w[n - 1 - i];
      for (int j = 0; j < SH; j++) begin
        tick();
        if (sck_dir !== DIR_IN) dir_bad++;
      end
      so_w = {so_w[30:0], so_out};
      sck_drv = 1'b1;
      rise_cyc = cyc;
      for (int j = 0; j < SH; j++) begin
        if (rx_cnt != rx0) break;
        tick();
        if (sck_dir !== DIR_IN) dir_bad++;
      end
    end
    for (int j = 0; j < 10 && rx_cnt == rx0; j++) tick();
    check("s_rx_cnt", rx_cnt - rx0, 1);
    check("s_so_bits", so_w, exp_so);
    check("s_sck_dir", dir_bad, 0);
    check("s_rx_lat", 32'((rx_cyc - rise_cyc) >= 1 && (rx_cyc - rise_cyc) <= SS + 3), 1);
    tick();
    check("s_idle", {bus.tx_ready, bus.busy}, 2'b10);
  endtask

  task automatic run_timeout();
    int rx0, e0, last;
    rx0 = rx_cnt; e0 = err_cnt; lb = 1'b0; sck_drv = 1'b1;
    start(1'b0, 1'b0, 1'b1, $urandom);
    repeat (TO + 50) tick();
    check("to_no_early", err_cnt - e0, 0);
    for (int i = 0; i < 4; i++) begin
      sck_drv = ~sck_drv;
      repeat (SH) tick();
    end
    sck_drv = ~sck_drv;
    last = cyc;
    for (int j = 0; j < TO + 20 && err_cnt == e0; j++) tick();
    check("to_err_cnt", err_cnt - e0, 1);
    check("to_err_lat", 32'((err_cyc - last) >= TO && (err_cyc - last) <= TO + SS + 3), 1);
    check("to_no_rx", rx_cnt - rx0, 0);
    tick();
    check("to_after", {bus.tx_ready, bus.err_timeout, bus.busy}, 3'b100);
    sck_drv = 1'b1;
    repeat (10) tick();
  endtask

  task automatic run_reset_mid();
    int rx0;
    rx0 = rx_cnt; lb = 1'b1;
    start(1'b1, 1'b0, 1'b1, 32'h5A5AF00F);
    repeat (40) tick();
    reset_n = 1'b0;
    tick();
    check_reset_vals("rst_a");
    repeat (3) tick();
    check_reset_vals("rst_b");
    reset_n = 1'b1;
    check("rst_rdy0", bus.tx_ready, 0);
    tick();
    check("rst_rdy1", {bus.tx_ready, so_dir}, 2'b11);
    repeat (5) tick();
    check("rst_no_rx", rx_cnt - rx0, 0);
    lb = 1'b0;
  endtask

  task automatic run_b2b();
    int rx0, a1, a2, r1;
    rx0 = rx_cnt; lb = 1'b1; a1 = -1; a2 = -1; r1 = -1;
    exp_q.push_back(32'h11);
    exp_q.push_back(32'h22);
    bus.cfg_master = 1'b1; bus.cfg_fast = 1'b1; bus.cfg_wide = 1'b0;
    bus.tx_data = 32'h11; bus.tx_valid = 1'b1;
    for (int i = 0; i < 20 && a1 < 0; i++) begin
      if (bus.tx_ready === 1'b1) a1 = cyc; else tick();
    end
    tick();
    bus.tx_data = 32'h22;
    for (int k = 0; k < 60 && rx_cnt == rx0; k++) begin
      if (k == 10) bus.cfg_wide = 1'b1;
      if (k == 20) bus.cfg_wide = 1'b0;
      tick();
    end
    r1 = rx_cyc;
    for (int i = 0; i < 10 && a2 < 0; i++) begin
      if (bus.tx_ready === 1'b1) a2 = cyc; else tick();
    end
    tick();
    bus.tx_valid = 1'b0;
    bus.cfg_wide = 1'b1;
    for (int k = 0; k < 60 && rx_cnt < rx0 + 2; k++) tick();
    check("b2b_lat1", r1 - a1, 2 * HF * 8 + 1);
    check("b2b_gap", a2 - r1, 1);
    check("b2b_lat2", rx_cyc - a2, 2 * HF * 8 + 1);
    check("b2b_rx_cnt", rx_cnt - rx0, 2);
    tick();
    lb = 1'b0;
    bus.cfg_wide = 1'b0;
  endtask

  initial begin
    n_checks = 0; n_fail = 0; cyc = 0; rx_cnt = 0; err_cnt = 0;
    rx_cyc = 0; err_cyc = 0; acc_cyc = 0;
    reset_n = 1'b0; sck_drv = 1'b1; si_drv = 1'b0; lb = 1'b0;
    bus.tx_valid = 1'b0; bus.tx_data = '0;
    bus.cfg_master = 1'b0; bus.cfg_fast = 1'b0; bus.cfg_wide = 1'b0;
    repeat (3) tick();
    check_reset_vals("init_rst");
    reset_n = 1'b1;
    tick();
    tick();
    check("init_idle", {bus.tx_ready, so_dir, so_out, bus.busy}, 4'b1110);
    bus.cfg_master = 1'b1;
    tick();
    check("sck_dir_m", sck_dir, DIR_OUT);
    bus.cfg_master = 1'b0;
    tick();
    check("sck_dir_s", sck_dir, DIR_IN);
    check("si_sd_dir", {si_dir, sd_dir}, 2'b00);

    run_master(1'b1, 1'b0, 32'h000000A5, 32'h0000003C, 1'b0);
    run_master(1'b0, 1'b1, 32'hDEADBEEF, 32'h0, 1'b1);
    run_slave(1'b1, 32'h12345678, 32'hCAFEF00D);
    run_timeout();
    run_reset_mid();
    run_b2b();
    for (int t = 0; t < 8; t++) begin
      if ($urandom_range(0, 1) == 1)
        run_master(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom, $urandom,
                   1'($urandom_range(0, 1)));
      else
        run_slave(1'($urandom_range(0, 1)), $urandom, $urandom);
    end
    check("exp_q_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
